adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 107 ++++++++++
 tb/tb_adder_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two-requester round-robin front end sharing one ripple adder, with a single-entry result register.
// Subtraction is compiled in only when ADDER_ARBITER_SUB_EN is defined.
module adder_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    input  logic             req0_sub,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             rsp_id
);

    localparam int unsigned MSB = WIDTH - 1;
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             last_q;
    logic             slot_free, gnt0, gnt1, accept;
    logic [WIDTH-1:0] op_x, op_y, op_yp, sum;
    logic [WIDTH:0]   carry;
    logic             sub;

    // Grant logic: last_q=1 means requester 1 won most recently, so requester 0 wins a tie.
    always_comb begin
        slot_free = rst_n & ((state_q == EMPTY) | rsp_ready);
        gnt0      = slot_free & req0_valid & (~req1_valid | last_q);
        gnt1      = slot_free & req1_valid & (~req0_valid | ~last_q);
        accept    = gnt0 | gnt1;
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

`ifdef ADDER_ARBITER_SUB_EN
    assign sub = gnt1 ? req1_sub : req0_sub;
`else
    logic unused_sub;
    assign unused_sub = req0_sub ^ req1_sub;
    assign sub = 1'b0;
`endif

    // Shared ripple adder; subtraction is x + ~y + 1.
    always_comb begin
        op_x     = gnt1 ? req1_x : req0_x;
        op_y     = gnt1 ? req1_y : req0_y;
        op_yp    = op_y ^ {WIDTH{sub}};
        carry    = '0;
        sum      = '0;
        carry[0] = sub;
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum[i]     = op_x[i] ^ op_yp[i] ^ carry[i];
            carry[i+1] = (op_x[i] & op_yp[i]) | (carry[i] & (op_x[i] ^ op_yp[i]));
        end
    end

    // Result-slot FSM next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (rsp_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Result register and round-robin pointer, loaded only on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= 1'b1;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rsp_ovf  <= 1'b0;
            rsp_id   <= 1'b0;
        end else if (accept) begin
            last_q   <= gnt1;
            rsp_sum  <= sum;
            rsp_cout <= carry[WIDTH];
            rsp_ovf  <= (op_x[MSB] == op_yp[MSB]) & (sum[MSB] != op_x[MSB]);
            rsp_id   <= gnt1;
        end
    end

    assign rsp_valid = (state_q == FULL);

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed, table-driven bench for adder_arbiter plus hand-written stall, reset and round-robin sequences.
// Expected values follow ADDER_ARBITER_SUB_EN when it is defined for the build.
module tb_adder_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_x, req0_y, req1_x, req1_y;
    logic        req0_sub, req1_sub;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_sum;
    logic        rsp_cout, rsp_ovf, rsp_id;

    int n_vec = 0;
    int n_bad = 0;

    adder_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req1_x(req1_x), .req1_y(req1_y),
        .req0_sub(req0_sub), .req1_sub(req1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_id(rsp_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [31:0] x0, y0;
        logic        s0;
        logic        v1;
        logic [31:0] x1, y1;
        logic        s1;
        logic        id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    initial begin
        // Pointer history: starts at 1, so each tie below goes to the requester not granted last.
        vecs[0] = '{1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0,
                    1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0,
                    1'b1, 32'h0000_0000, 1'b1, 1'b0};
`ifdef ADDER_ARBITER_SUB_EN
        vecs[2] = '{1'b1, 32'd5, 32'd7, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0,
                    1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
`else
        vecs[2] = '{1'b1, 32'd5, 32'd7, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0,
                    1'b0, 32'h0000_000C, 1'b0, 1'b0};
`endif
        vecs[3] = '{1'b1, 32'd1, 32'd2, 1'b0, 1'b1, 32'd10, 32'd20, 1'b0,
                    1'b1, 32'd30, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 32'd3, 32'd4, 1'b0, 1'b1, 32'd10, 32'd20, 1'b0,
                    1'b0, 32'd7, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0,
                    1'b1, 32'h0000_0000, 1'b1, 1'b1};
`ifdef ADDER_ARBITER_SUB_EN
        vecs[6] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0,
                    1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
`else
        vecs[6] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0,
                    1'b0, 32'h8000_0001, 1'b0, 1'b0};
`endif

        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_x = 32'd1; req0_y = 32'd1; req1_x = 32'd2; req1_y = 32'd2;
        req0_sub = 1'b0; req1_sub = 1'b0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_sum", rsp_sum, 32'd0);
        chk("reset rsp_cout", 32'(rsp_cout), 32'd0);
        chk("reset rsp_ovf", 32'(rsp_ovf), 32'd0);
        chk("reset rsp_id", 32'(rsp_id), 32'd0);
        chk("reset req0_ready", 32'(req0_ready), 32'd0);
        chk("reset req1_ready", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single operations
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            req0_valid = vecs[i].v0; req0_x = vecs[i].x0; req0_y = vecs[i].y0; req0_sub = vecs[i].s0;
            req1_valid = vecs[i].v1; req1_x = vecs[i].x1; req1_y = vecs[i].y1; req1_sub = vecs[i].s1;
            #1;
            chk($sformatf("v%0d req0_ready", i), 32'(req0_ready), 32'(vecs[i].id == 1'b0));
            chk($sformatf("v%0d req1_ready", i), 32'(req1_ready), 32'(vecs[i].id == 1'b1));
            @(posedge clk);
            #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("v%0d rsp_sum", i), rsp_sum, vecs[i].sum);
            chk($sformatf("v%0d rsp_cout", i), 32'(rsp_cout), 32'(vecs[i].cout));
            chk($sformatf("v%0d rsp_ovf", i), 32'(rsp_ovf), 32'(vecs[i].ovf));
            chk($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(vecs[i].id));
        end

        // Backpressure: hold FULL for 3 cycles, then drain and accept in the same cycle
        @(negedge clk);
        req0_valid = 1'b1; req0_x = 32'd1; req0_y = 32'd1; req0_sub = 1'b0;
        @(posedge clk);
        #1;
        req0_valid = 1'b0; rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_x = 32'd5; req1_y = 32'd5; req1_sub = 1'b0;
        chk("stall first sum", rsp_sum, 32'd2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d req0_ready", c), 32'(req0_ready), 32'd0);
            chk($sformatf("stall%0d req1_ready", c), 32'(req1_ready), 32'd0);
            chk($sformatf("stall%0d rsp_valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("stall%0d rsp_sum", c), rsp_sum, 32'd2);
            chk($sformatf("stall%0d rsp_id", c), 32'(rsp_id), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        chk("drain req1_ready", 32'(req1_ready), 32'd1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        chk("drain rsp_valid", 32'(rsp_valid), 32'd1);
        chk("drain rsp_sum", rsp_sum, 32'd10);
        chk("drain rsp_id", 32'(rsp_id), 32'd1);
        @(posedge clk);
        #1;
        chk("empty rsp_valid", 32'(rsp_valid), 32'd0);

        // Reset while FULL: result is dropped at once
        @(negedge clk);
        req0_valid = 1'b1; req0_x = 32'd9; req0_y = 32'd9;
        @(posedge clk);
        #1;
        req0_valid = 1'b0; rsp_ready = 1'b0;
        chk("prereset rsp_valid", 32'(rsp_valid), 32'd1);
        chk("prereset rsp_sum", rsp_sum, 32'd18);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midreset rsp_sum", rsp_sum, 32'd0);
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        req0_x = 32'd100; req0_y = 32'd0; req1_x = 32'd200; req1_y = 32'd0;
        #1;
        chk("midreset req0_ready", 32'(req0_ready), 32'd0);
        chk("midreset req1_ready", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("inreset rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Round robin with both valid: first tie after reset goes to requester 0
        begin
            int n0, n1;
            n0 = 0; n1 = 0;
            for (int i = 0; i < 8; i++) begin
                if (i > 0) @(negedge clk);
                #1;
                chk($sformatf("rr%0d req0_ready", i), 32'(req0_ready), 32'(i % 2 == 0));
                chk($sformatf("rr%0d req1_ready", i), 32'(req1_ready), 32'(i % 2 == 1));
                @(posedge clk);
                #1;
                chk($sformatf("rr%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
                chk($sformatf("rr%0d rsp_id", i), 32'(rsp_id), 32'(i % 2));
                chk($sformatf("rr%0d rsp_sum", i), rsp_sum,
                    (i % 2 == 0) ? 32'(100 + n0) : 32'(200 + n1));
                if (i % 2 == 0) begin
                    n0++;
                    req0_x = 32'(100 + n0);
                    if (n0 == 4) req0_valid = 1'b0;
                end else begin
                    n1++;
                    req1_x = 32'(200 + n1);
                    if (n1 == 4) req1_valid = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("final rsp_valid", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
